// File: rtl/redirect_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// redirect_arbiter_pkg
//   Shared types and helpers for the PC-redirect arbiter.
//   TAGW        : ROB tag width; tags wrap modulo 2**TAGW.
//   ST_IDLE/HOLD: arbiter FSM encodings.
//   redirect_req_t : one redirect request {pc, tag}.
//   rob_age()   : distance of a tag from the ROB head (modulo 2**TAGW).
//   is_older()  : true when tag a is strictly older than tag b.
// ---------------------------------------------------------------------------
package redirect_arbiter_pkg;

    localparam int TAGW = 6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic [31:0]     pc;
        logic [TAGW-1:0] tag;
    } redirect_req_t;

    // Unsigned subtraction in TAGW bits gives the wrapped distance from head.
    function automatic logic [TAGW-1:0] rob_age(input logic [TAGW-1:0] tag,
                                                 input logic [TAGW-1:0] head);
        return tag - head;
    endfunction

    function automatic logic is_older(input logic [TAGW-1:0] a,
                                      input logic [TAGW-1:0] b,
                                      input logic [TAGW-1:0] head);
        return rob_age(a, head) < rob_age(b, head);
    endfunction

endpackage

// File: rtl/redirect_age_pick.sv
// ---------------------------------------------------------------------------
// redirect_age_pick
//   Combinational oldest-of-N selection over the incoming request tags.
//   Ties on age resolve to the lowest source index.
//   valid   : per-source candidate valid
//   tags    : per-source ROB tag
//   head    : ROB head tag (age reference)
//   win_idx : index of the oldest valid source
//   win_vld : at least one source is valid
// ---------------------------------------------------------------------------
module redirect_age_pick
    import redirect_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]           valid,
    input  logic [NREQ-1:0][TAGW-1:0] tags,
    input  logic [TAGW-1:0]           head,
    output logic [IDXW-1:0]           win_idx,
    output logic                      win_vld
);

    logic [TAGW-1:0] best_tag;

    // Strict "older" test keeps the earlier (lower index) source on a tie.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        best_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (valid[i] && (!win_vld || is_older(tags[i], best_tag, head))) begin
                win_vld  = 1'b1;
                win_idx  = IDXW'(i);
                best_tag = tags[i];
            end
        end
    end

endmodule

// File: rtl/redirect_arbiter.sv
// ---------------------------------------------------------------------------
// redirect_arbiter
//   Collects PC-redirect requests from NREQ back-end sources, picks the
//   oldest by ROB tag and issues one registered redirect pulse to fetch.
//   After each redirect it holds off for HOLD_CYCLES; the oldest request
//   seen during hold-off is kept in a single pending slot and issued when
//   the hold-off expires. Requests younger than the last issued redirect
//   are wrong-path and dropped.
//
//   Optional feature macro: REDIRECT_STATS_EN adds saturating counters
//   issued_cnt_o / dropped_cnt_o.
//
//   Handshake: req_valid_i is a one-cycle strobe with no backpressure; a
//   request that is neither issued nor stored in the pending slot in the
//   cycle it is presented is lost. redirect_o is a one-cycle pulse with
//   redirect_pc_o / redirect_tag_o valid in the same cycle.
//
//   Ports
//     clk_i, reset_ni         clock, async active-low reset
//     req_valid_i/pc_i/tag_i  per-source redirect requests
//     head_tag_i, head_adv_i  ROB head tag and retire strobe
//     redirect_o/pc_o/tag_o   registered redirect to fetch
//     busy_o                  hold-off active or request pending
//     fsm_state_o             current FSM state (ST_IDLE / ST_HOLD)
//     issued_cnt_o, dropped_cnt_o  (REDIRECT_STATS_EN only)
// ---------------------------------------------------------------------------
module redirect_arbiter
    import redirect_arbiter_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ-1:0][31:0]     req_pc_i,
    input  logic [NREQ-1:0][TAGW-1:0] req_tag_i,
    input  logic [TAGW-1:0]           head_tag_i,
    input  logic                      head_adv_i,
    output logic                      redirect_o,
    output logic [31:0]               redirect_pc_o,
    output logic [TAGW-1:0]           redirect_tag_o,
    output logic                      busy_o,
    output logic [0:0]                fsm_state_o
`ifdef REDIRECT_STATS_EN
    ,
    output logic [15:0]               issued_cnt_o,
    output logic [15:0]               dropped_cnt_o
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [0:0]      state_q;
    logic [CNTW-1:0] cnt_q;
    redirect_req_t   pend_q;
    logic            pend_vld_q;
    logic [TAGW-1:0] last_tag_q;
    logic            last_vld_q;

    logic [NREQ-1:0] squash;
    logic [NREQ-1:0] cand_vld;
    logic [IDXW-1:0] in_idx;
    logic            in_vld;
    redirect_req_t   in_req;
    logic            in_wins;
    redirect_req_t   sel_req;
    logic            sel_vld;
    logic            issue;
    logic            last_clear;

    // last_tag_q is already updated in the cycle redirect_o is high, so a
    // request arriving alongside a redirect is filtered against it.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            squash[i] = last_vld_q && !is_older(req_tag_i[i], last_tag_q, head_tag_i);
        end
        cand_vld = req_valid_i & ~squash;
    end

    redirect_age_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .valid   (cand_vld),
        .tags    (req_tag_i),
        .head    (head_tag_i),
        .win_idx (in_idx),
        .win_vld (in_vld)
    );

    // Merge the incoming winner with the pending slot. The pending entry is
    // only displaced by a strictly older request. pend_vld_q is only ever
    // set in HOLD, so in IDLE this reduces to the incoming winner.
    always_comb begin
        in_req.pc  = req_pc_i[in_idx];
        in_req.tag = req_tag_i[in_idx];
        in_wins    = in_vld && (!pend_vld_q || is_older(in_req.tag, pend_q.tag, head_tag_i));
        sel_req    = in_wins ? in_req : pend_q;
        sel_vld    = in_vld || pend_vld_q;
        issue      = sel_vld && ((state_q == ST_IDLE) || (cnt_q == '0));
        last_clear = head_adv_i && (head_tag_i == last_tag_q);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pend_q         <= '0;
            pend_vld_q     <= 1'b0;
            last_tag_q     <= '0;
            last_vld_q     <= 1'b0;
            redirect_o     <= 1'b0;
            redirect_pc_o  <= '0;
            redirect_tag_o <= '0;
        end else begin
            redirect_o <= issue;
            if (issue) begin
                redirect_pc_o  <= sel_req.pc & 32'hFFFF_FFFC;
                redirect_tag_o <= sel_req.tag;
                last_tag_q     <= sel_req.tag;
                last_vld_q     <= 1'b1;
                pend_vld_q     <= 1'b0;
                state_q        <= ST_HOLD;
                cnt_q          <= CNTW'(HOLD_CYCLES - 1);
            end else begin
                // Retirement of the last redirecting instruction ends the
                // wrong-path window; an issue in the same cycle takes priority.
                if (last_clear) begin
                    last_vld_q <= 1'b0;
                end
                if (state_q == ST_HOLD) begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q      <= cnt_q - CNTW'(1);
                        pend_q     <= sel_req;
                        pend_vld_q <= sel_vld;
                    end
                end
            end
        end
    end

    assign busy_o      = (state_q == ST_HOLD) | pend_vld_q;
    assign fsm_state_o = state_q;

`ifdef REDIRECT_STATS_EN
    logic [15:0] n_drop;
    logic [16:0] drop_sum;

    // Every valid request except the one that was issued or stored is lost.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NREQ; i++) begin
            n_drop = n_drop + {15'b0, req_valid_i[i]};
        end
        n_drop   = n_drop - {15'b0, in_wins};
        drop_sum = {1'b0, dropped_cnt_o} + {1'b0, n_drop};
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            issued_cnt_o  <= '0;
            dropped_cnt_o <= '0;
        end else begin
            if (issue && (issued_cnt_o != 16'hFFFF)) begin
                issued_cnt_o <= issued_cnt_o + 16'd1;
            end
            dropped_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule
